// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons with one shared saturating update path.
// One neuron is updated per enabled clock in round-robin order; results are registered.
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int W         = 16,
    parameter int VTH       = 3277,
    parameter int DV        = 6,
    parameter int DU        = 6,
    parameter int V_RESET   = 0,
    parameter int REFRAC    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_NEURONS*W-1:0]     I_app,
    input  logic [W-1:0]               I_fb,
    output logic                       out_valid,
    output logic [$clog2(N_NEURONS)-1:0] out_idx,
    output logic [W-1:0]               V_mem,
    output logic [W-1:0]               U_leak,
    output logic                       spike,
    output logic                       sweep_done,
    output logic [N_NEURONS-1:0]       spike_vec
);

    localparam int IW = $clog2(N_NEURONS);
    localparam int EW = W + 2;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic signed [W-1:0]  MAX_W    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_W    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXT_MAX  = EW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [EW-1:0] EXT_MIN  = {{(EW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  L_VTH    = VTH[W-1:0];
    localparam logic signed [W-1:0]  L_VRESET = V_RESET[W-1:0];
    localparam logic [RW-1:0]        L_REFRAC = RW'(REFRAC);
    localparam logic [IW-1:0]        LAST_IDX = IW'(N_NEURONS - 1);

    function automatic logic signed [EW-1:0] sext(input logic signed [W-1:0] a);
        return {{(EW-W){a[W-1]}}, a};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [EW-1:0] x);
        if (x > EXT_MAX) begin
            return MAX_W;
        end else if (x < EXT_MIN) begin
            return MIN_W;
        end
        return x[W-1:0];
    endfunction

    logic signed [W-1:0]  r_v    [N_NEURONS];
    logic signed [W-1:0]  r_u    [N_NEURONS];
    logic [RW-1:0]        r_rcnt [N_NEURONS];
    logic [IW-1:0]        r_idx;
    logic [N_NEURONS-1:0] r_acc;

    logic                 r_out_valid;
    logic [IW-1:0]        r_out_idx;
    logic signed [W-1:0]  r_v_mem;
    logic signed [W-1:0]  r_u_leak;
    logic                 r_spike;
    logic                 r_sweep_done;
    logic [N_NEURONS-1:0] r_spike_vec;

    logic signed [W-1:0]  w_u;
    logic signed [W-1:0]  w_v;
    logic signed [W-1:0]  w_iapp;
    logic signed [W-1:0]  w_ifb;
    logic signed [W-1:0]  w_un;
    logic signed [W-1:0]  w_vc;
    logic signed [W-1:0]  w_v_new;
    logic [RW-1:0]        w_rcnt;
    logic [RW-1:0]        w_rcnt_new;
    logic                 w_refrac;
    logic                 w_fire;
    logic                 w_last;
    logic [N_NEURONS-1:0] w_spike_bit;
    logic [N_NEURONS-1:0] w_acc_next;

    always_comb begin
        w_u         = r_u[r_idx];
        w_v         = r_v[r_idx];
        w_rcnt      = r_rcnt[r_idx];
        w_iapp      = I_app[r_idx*W +: W];
        w_ifb       = I_fb;
        // Sums are formed two bits wider than the state so saturation sees the true value.
        w_un        = sat(sext(w_u) - sext(w_u >>> DU) + sext(w_iapp) + sext(w_ifb));
        w_vc        = sat(sext(w_v) - sext(w_v >>> DV) + sext(w_un));
        w_refrac    = (w_rcnt != '0);
        w_fire      = !w_refrac && (w_vc >= L_VTH);
        w_v_new     = (w_refrac || w_fire) ? L_VRESET : w_vc;
        w_rcnt_new  = w_rcnt;
        if (w_refrac) begin
            w_rcnt_new = w_rcnt - RW'(1);
        end else if (w_fire) begin
            w_rcnt_new = L_REFRAC;
        end
        w_last      = (r_idx == LAST_IDX);
        w_spike_bit = '0;
        w_spike_bit[r_idx] = w_fire;
        w_acc_next  = r_acc | w_spike_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k]    <= '0;
                r_u[k]    <= '0;
                r_rcnt[k] <= '0;
            end
            r_idx        <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_idx    <= '0;
            r_v_mem      <= '0;
            r_u_leak     <= '0;
            r_spike      <= 1'b0;
            r_sweep_done <= 1'b0;
            r_spike_vec  <= '0;
        end else if (enable) begin
            r_v[r_idx]    <= w_v_new;
            r_u[r_idx]    <= w_un;
            r_rcnt[r_idx] <= w_rcnt_new;
            r_idx         <= w_last ? '0 : r_idx + IW'(1);
            r_out_valid   <= 1'b1;
            r_out_idx     <= r_idx;
            r_v_mem       <= w_v_new;
            r_u_leak      <= w_un;
            r_spike       <= w_fire;
            r_sweep_done  <= w_last;
            if (w_last) begin
                r_spike_vec <= w_acc_next;
                r_acc       <= '0;
            end else begin
                r_acc       <= w_acc_next;
            end
        end else begin
            r_out_valid  <= 1'b0;
            r_spike      <= 1'b0;
            r_sweep_done <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_idx    = r_out_idx;
    assign V_mem      = r_v_mem;
    assign U_leak     = r_u_leak;
    assign spike      = r_spike;
    assign sweep_done = r_sweep_done;
    assign spike_vec  = r_spike_vec;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: hand-computed expectations plus an integer reference model
// that predicts every registered update.
module tb_lif_neuron_array;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] I_app;
    logic [15:0] I_fb;
    logic        out_valid;
    logic [1:0]  out_idx;
    logic [15:0] V_mem;
    logic [15:0] U_leak;
    logic        spike;
    logic        sweep_done;
    logic [3:0]  spike_vec;

    lif_neuron_array dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .I_app      (I_app),
        .I_fb       (I_fb),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .V_mem      (V_mem),
        .U_leak     (U_leak),
        .spike      (spike),
        .sweep_done (sweep_done),
        .spike_vec  (spike_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int       mv [4];
    int       mu [4];
    int       mr [4];
    int       m_idx;
    logic [3:0] m_acc;
    logic [3:0] m_vec;

    int e_idx;
    int e_v;
    int e_u;
    int last_v [4];
    int last_u [4];
    int spk_cnt [4];
    int sd_cnt;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mv[k] = 0;
            mu[k] = 0;
            mr[k] = 0;
        end
        m_idx = 0;
        m_acc = '0;
        m_vec = '0;
        e_idx = 0;
        e_v   = 0;
        e_u   = 0;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) spk_cnt[k] = 0;
        sd_cnt = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_vmem"}, $signed(V_mem), 0);
        chk({tag, "_uleak"}, $signed(U_leak), 0);
        chk({tag, "_spike"}, spike, 0);
        chk({tag, "_sdone"}, sweep_done, 0);
        chk({tag, "_svec"}, spike_vec, 0);
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk_zero(tag);
        end
        reset = 1'b1;
        model_reset();
    endtask

    // One enabled update: predict, clock, compare.
    task automatic run_cycle();
        int  k;
        int  ia;
        int  ifb;
        int  un;
        int  vc;
        int  vn;
        bit  fire;
        k   = m_idx;
        ia  = int'($signed(I_app[k*16 +: 16]));
        ifb = int'($signed(I_fb));
        un  = sat16(mu[k] - (mu[k] >>> 6) + ia + ifb);
        vc  = sat16(mv[k] - (mv[k] >>> 6) + un);
        fire = 1'b0;
        if (mr[k] > 0) begin
            vn = 0;
            mr[k] = mr[k] - 1;
        end else if (vc >= 3277) begin
            vn = 0;
            mr[k] = 2;
            fire = 1'b1;
        end else begin
            vn = vc;
        end
        mu[k] = un;
        mv[k] = vn;
        if (fire) m_acc[k] = 1'b1;
        if (k == 3) begin
            m_vec = m_acc;
            m_acc = '0;
        end
        e_idx = k;
        e_v   = vn;
        e_u   = un;
        m_idx = (k + 1) % 4;
        @(posedge clk);
        #1;
        chk("valid", out_valid, 1);
        chk("idx", out_idx, k);
        chk("vmem", $signed(V_mem), vn);
        chk("uleak", $signed(U_leak), un);
        chk("spike", spike, fire);
        chk("sweep_done", sweep_done, (k == 3));
        chk("spike_vec", spike_vec, m_vec);
        last_v[out_idx] = int'($signed(V_mem));
        last_u[out_idx] = int'($signed(U_leak));
        if (spike) spk_cnt[out_idx]++;
        if (sweep_done) sd_cnt++;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        I_fb   = '0;
        I_app  = {4{16'h7FFF}};
        model_reset();
        clear_stats();

        // Reset held with full-scale input, then first update of neuron 0 fires.
        do_reset(3, "rst");
        run_cycle();
        chk("t1_idx", out_idx, 0);
        chk("t1_vmem", $signed(V_mem), 0);
        chk("t1_uleak", $signed(U_leak), 32767);
        chk("t1_spike", spike, 1);
        repeat (3) run_cycle();
        chk("t1_vec", spike_vec, 4'b1111);

        // Zero input: nothing moves, no spikes, sweep_done every 4th cycle.
        I_app = '0;
        do_reset(1, "rst2");
        clear_stats();
        repeat (4000) run_cycle();
        chk("t2_spikes", spk_cnt[0] + spk_cnt[1] + spk_cnt[2] + spk_cnt[3], 0);
        chk("t2_sweeps", sd_cnt, 1000);

        // Full-scale drive on neuron 0 only: fires every 3rd sweep, U pinned at max.
        I_app = '0;
        I_app[15:0] = 16'h7FFF;
        do_reset(1, "rst3");
        for (int s = 0; s < 9; s++) begin
            repeat (4) run_cycle();
            chk("t3_vec", spike_vec, (s % 3 == 0) ? 4'b0001 : 4'b0000);
            chk("t3_u0", last_u[0], 32767);
        end

        // Negative full scale on neuron 1: both states clamp at min, no spikes.
        I_app = '0;
        I_app[31:16] = 16'h8000;
        do_reset(1, "rst4");
        clear_stats();
        repeat (800) run_cycle();
        chk("t4_u1", last_u[1], -32768);
        chk("t4_v1", last_v[1], -32768);
        chk("t4_spikes", spk_cnt[0] + spk_cnt[1] + spk_cnt[2] + spk_cnt[3], 0);

        // Unit drive on neuron 2: U settles at 64, V climbs past threshold repeatedly.
        I_app = '0;
        I_app[47:32] = 16'h0001;
        do_reset(1, "rst5");
        clear_stats();
        repeat (12000) run_cycle();
        chk("t5_u2", last_u[2], 64);
        chk("t5_n2_fires", (spk_cnt[2] > 1) ? 1 : 0, 1);
        chk("t5_others", spk_cnt[0] + spk_cnt[1] + spk_cnt[3], 0);

        // Stall mid-sweep: outputs hold, strobes drop, scan resumes where it stopped.
        repeat (2) run_cycle();
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 0);
            chk("stall_spike", spike, 0);
            chk("stall_sdone", sweep_done, 0);
            chk("stall_idx", out_idx, e_idx);
            chk("stall_vmem", $signed(V_mem), e_v);
            chk("stall_uleak", $signed(U_leak), e_u);
            chk("stall_svec", spike_vec, m_vec);
        end
        enable = 1'b1;
        repeat (40) run_cycle();

        // Feedback current shared by every neuron.
        I_app = {16'sd300, -16'sd40, 16'sd5000, 16'sd90};
        I_fb  = -16'sd7;
        repeat (400) run_cycle();

        // Reset with a partial sweep in flight; spike_vec must not pick up the discarded bits.
        I_app = {4{16'h7FFF}};
        I_fb  = '0;
        do_reset(1, "rst7a");
        repeat (3) run_cycle();
        chk("t7_pre_idx", out_idx, 2);
        do_reset(1, "rst7");
        repeat (3) begin
            run_cycle();
            chk("t7_vec_hold", spike_vec, 0);
        end
        run_cycle();
        chk("t7_vec_full", spike_vec, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
